// File: rtl/spi_master_n_pkg.sv
// Shared types and helpers for the multi-device SPI master.
package spi_master_n_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Chip-select index width; a single device still gets one bit.
    function automatic int unsigned csw_of(input int unsigned ncs);
        return (ncs > 1) ? $clog2(ncs) : 1;
    endfunction

endpackage

// File: rtl/spi_master_n_if.sv
// Host-side request/response bundle of the SPI master.
interface spi_master_n_if import spi_master_n_pkg::*; #(
    parameter int unsigned NCS   = 2,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIVW  = 4
);
    localparam int unsigned CSW = csw_of(NCS);

    logic             wvalid;
    logic [WIDTH-1:0] wdata;
    logic [CSW-1:0]   wcs;
    logic [DIVW-1:0]  div;
    logic             cpol;
    logic             cpha;
    logic             busy;
    logic             rvalid;
    logic [WIDTH-1:0] rdata;
    logic             ovr;

    modport master (
        output wvalid, wdata, wcs, div, cpol, cpha,
        input  busy, rvalid, rdata, ovr
    );

    modport slave (
        input  wvalid, wdata, wcs, div, cpol, cpha,
        output busy, rvalid, rdata, ovr
    );

endinterface

// File: rtl/spi_master_n_tick_gen.sv
// Half-period tick: down-counter reloaded with div on every tick.
module spi_tick_gen #(
    parameter int unsigned DIVW = 4
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            load,
    input  logic            en,
    input  logic [DIVW-1:0] div,
    output logic            tick_c
);

    logic [DIVW-1:0] cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= div;
        end else if (en) begin
            cnt_q <= (cnt_q == '0) ? div : cnt_q - DIVW'(1);
        end
    end

    assign tick_c = en && (cnt_q == '0);

endmodule

// File: rtl/spi_master_n.sv
// SPI master for NCS devices on a shared SCK/MOSI pair with per-device MISO;
// runtime divider and CPOL/CPHA, busy/rvalid handshake and overrun pulse.
module spi_master_n import spi_master_n_pkg::*; #(
    parameter int unsigned NCS   = 2,
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DIVW  = 4
) (
    input  logic           clock,
    input  logic           reset_n,
    spi_master_n_if.slave  host,
    output logic           sck,
    output logic           mosi,
    output logic [NCS-1:0] cs,
    input  logic [NCS-1:0] miso
);

    localparam int unsigned CSW = csw_of(NCS);
    localparam int unsigned ECW = $clog2(2 * WIDTH);

    spi_state_e       state_q, state_d;
    logic             pend_q, pend_d;
    logic [WIDTH-1:0] tx_q, tx_d;
    logic [WIDTH-1:0] rx_q, rx_d;
    logic [ECW-1:0]   ecnt_q, ecnt_d;
    logic [CSW-1:0]   wcs_q, wcs_d;
    logic [DIVW-1:0]  div_q, div_d;
    spi_mode_t        mode_q, mode_d;
    logic             sck_q, sck_d;
    logic             mosi_q, mosi_d;
    logic [NCS-1:0]   cs_q, cs_d;
    logic             busy_q, busy_d;
    logic             rvalid_q, rvalid_d;
    logic             ovr_q, ovr_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;

    logic             load_c;
    logic             tick_c;
    logic             miso_bit_c;
    logic [NCS-1:0]   cs_sel_n_c;
    logic             sample_c;
    logic             shift_c;
    logic             last_c;

    spi_tick_gen #(.DIVW(DIVW)) u_tick (
        .clock   (clock),
        .reset_n (reset_n),
        .load    (load_c),
        .en      (state_q != IDLE),
        .div     (div_q),
        .tick_c  (tick_c)
    );

    // Decode the latched index; an out-of-range index selects nothing and reads 0.
    always_comb begin
        miso_bit_c = 1'b0;
        cs_sel_n_c = '1;
        for (int unsigned i = 0; i < NCS; i++) begin
            if (wcs_q == CSW'(i)) begin
                miso_bit_c    = miso[i];
                cs_sel_n_c[i] = 1'b0;
            end
        end
    end

    // Even edge counts are leading edges; with cpha=1 the first leading edge keeps the MSB.
    assign sample_c = ~ecnt_q[0] ^ mode_q.cpha;
    assign shift_c  = ~sample_c & ~(mode_q.cpha & (ecnt_q == '0));
    assign last_c   = (ecnt_q == ECW'(2 * WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        pend_d   = 1'b0;
        tx_d     = tx_q;
        rx_d     = rx_q;
        ecnt_d   = ecnt_q;
        wcs_d    = wcs_q;
        div_d    = div_q;
        mode_d   = mode_q;
        sck_d    = sck_q;
        mosi_d   = mosi_q;
        cs_d     = cs_q;
        busy_d   = busy_q;
        rvalid_d = 1'b0;
        ovr_d    = 1'b0;
        rdata_d  = rdata_q;
        load_c   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_q) begin
                    sck_d   = mode_q.cpol;
                    cs_d    = cs_sel_n_c;
                    busy_d  = 1'b1;
                    mosi_d  = tx_q[WIDTH-1];
                    ecnt_d  = '0;
                    rx_d    = '0;
                    load_c  = 1'b1;
                    ovr_d   = host.wvalid;
                    state_d = SETUP;
                end else begin
                    sck_d = host.cpol;
                    if (host.wvalid) begin
                        pend_d = 1'b1;
                        tx_d   = host.wdata;
                        wcs_d  = host.wcs;
                        div_d  = host.div;
                        mode_d = '{cpol: host.cpol, cpha: host.cpha};
                    end
                end
            end

            SETUP: begin
                ovr_d = host.wvalid;
                if (tick_c) begin
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                ovr_d = host.wvalid;
                if (tick_c) begin
                    sck_d  = ~sck_q;
                    ecnt_d = ecnt_q + ECW'(1);
                    if (sample_c) begin
                        rx_d = {rx_q[WIDTH-2:0], miso_bit_c};
                    end
                    if (shift_c) begin
                        tx_d   = {tx_q[WIDTH-2:0], 1'b0};
                        mosi_d = tx_q[WIDTH-2];
                    end
                    if (last_c) begin
                        state_d = HOLD;
                    end
                end
            end

            HOLD: begin
                ovr_d = host.wvalid;
                if (tick_c) begin
                    cs_d     = '1;
                    busy_d   = 1'b0;
                    rdata_d  = rx_q;
                    rvalid_d = 1'b1;
                    state_d  = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            pend_q   <= 1'b0;
            tx_q     <= '0;
            rx_q     <= '0;
            ecnt_q   <= '0;
            wcs_q    <= '0;
            div_q    <= '0;
            mode_q   <= '0;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            cs_q     <= '1;
            busy_q   <= 1'b0;
            rvalid_q <= 1'b0;
            ovr_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
            ecnt_q   <= ecnt_d;
            wcs_q    <= wcs_d;
            div_q    <= div_d;
            mode_q   <= mode_d;
            sck_q    <= sck_d;
            mosi_q   <= mosi_d;
            cs_q     <= cs_d;
            busy_q   <= busy_d;
            rvalid_q <= rvalid_d;
            ovr_q    <= ovr_d;
            rdata_q  <= rdata_d;
        end
    end

    assign sck         = sck_q;
    assign mosi        = mosi_q;
    assign cs          = cs_q;
    assign host.busy   = busy_q;
    assign host.rvalid = rvalid_q;
    assign host.rdata  = rdata_q;
    assign host.ovr    = ovr_q;

endmodule

// File: tb/tb_spi_master_n.sv
// Directed bench for spi_master_n: modes, timing, overrun, back-to-back, reset, bad index.
`timescale 1ns/1ps
module tb_spi_master_n;

    localparam int unsigned NCS   = 2;
    localparam int unsigned WIDTH = 16;
    localparam int unsigned DIVW  = 4;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #16 clock = ~clock;

    spi_master_n_if #(.NCS(NCS), .WIDTH(WIDTH), .DIVW(DIVW)) bus ();
    spi_master_n_if #(.NCS(3),   .WIDTH(WIDTH), .DIVW(DIVW)) bus3 ();

    logic           sck, mosi;
    logic [NCS-1:0] cs, miso;
    logic           sck3, mosi3;
    logic [2:0]     cs3;
    logic [2:0]     miso3 = 3'b111;

    spi_master_n #(.NCS(NCS), .WIDTH(WIDTH), .DIVW(DIVW)) dut (
        .clock(clock), .reset_n(reset_n), .host(bus),
        .sck(sck), .mosi(mosi), .cs(cs), .miso(miso)
    );

    spi_master_n #(.NCS(3), .WIDTH(WIDTH), .DIVW(DIVW)) dut3 (
        .clock(clock), .reset_n(reset_n), .host(bus3),
        .sck(sck3), .mosi(mosi3), .cs(cs3), .miso(miso3)
    );

    int n_pass = 0;
    int n_chk  = 0;

    // Device model: echoes a word on the selected MISO and records MOSI at its sample edges.
    logic [WIDTH-1:0] echo    = '0;
    int               dev_idx = 0;
    logic             m_cpol  = 1'b0;
    logic             m_cpha  = 1'b0;
    int               dev_cnt = 0;
    logic [WIDTH-1:0] mosi_cap = '0;
    int               rise_cnt = 0;
    logic             busy_prev = 1'b0;
    logic             sck_prev  = 1'b0;
    logic [WIDTH-1:0] dev_word;
    logic             dev_bit;

    assign dev_word = echo << dev_cnt;
    assign dev_bit  = (dev_cnt >= 0) ? dev_word[WIDTH-1] : 1'b0;
    assign miso     = dev_bit ? (NCS'(1) << dev_idx) : '0;

    always @(negedge clock) begin
        busy_prev <= bus.busy;
        sck_prev  <= sck;
        if (bus.busy && !busy_prev) begin
            dev_cnt  <= m_cpha ? -1 : 0;
            mosi_cap <= '0;
            rise_cnt <= 0;
        end else if (!cs[dev_idx] && (sck != sck_prev)) begin
            if (sck && !sck_prev) rise_cnt <= rise_cnt + 1;
            if ((sck != m_cpol) != m_cpha) mosi_cap <= {mosi_cap[WIDTH-2:0], mosi};
            if ((sck != m_cpol) == m_cpha) dev_cnt <= dev_cnt + 1;
        end
    end

    task automatic kick(input logic [WIDTH-1:0] wd, input int cs_i, input int dv,
                        input logic pol, input logic pha);
        @(negedge clock);
        bus.wdata  = wd;
        bus.wcs    = 1'(cs_i);
        bus.div    = 4'(dv);
        bus.cpol   = pol;
        bus.cpha   = pha;
        bus.wvalid = 1'b1;
        @(posedge clock);
        #1;
        bus.wvalid = 1'b0;
    endtask

    task automatic wait_rv(input int limit, output int at);
        at = -1;
        for (int k = 1; k <= limit; k++) begin
            @(posedge clock);
            #1;
            if (bus.rvalid) begin
                at = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        n_chk++; if (cs !== 2'b11) $display("FAIL reset_cs: got %b want 11", cs); else n_pass++;
        n_chk++; if (sck !== 1'b0) $display("FAIL reset_sck: got %b want 0", sck); else n_pass++;
        n_chk++; if (mosi !== 1'b0) $display("FAIL reset_mosi: got %b want 0", mosi); else n_pass++;
        n_chk++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy); else n_pass++;
        n_chk++; if (bus.rvalid !== 1'b0 || bus.ovr !== 1'b0)
            $display("FAIL reset_pulses: got rvalid=%b ovr=%b want 0 0", bus.rvalid, bus.ovr); else n_pass++;
        n_chk++; if (bus.rdata !== 16'h0000) $display("FAIL reset_rdata: got %h want 0000", bus.rdata); else n_pass++;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) @(posedge clock);
    endtask

    task automatic test_mode0();
        int at;
        int cs_bad;
        logic busy1;
        echo = 16'h3C81; dev_idx = 1; m_cpol = 1'b0; m_cpha = 1'b0;
        kick(16'hA55A, 1, 0, 1'b0, 1'b0);
        at = -1; cs_bad = 0; busy1 = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clock);
            #1;
            if (k == 1) busy1 = bus.busy;
            if (k <= 34 && cs !== 2'b01) cs_bad++;
            if (bus.rvalid) begin
                at = k;
                break;
            end
        end
        n_chk++; if (busy1 !== 1'b1) $display("FAIL mode0_busy_edge1: got %b want 1", busy1); else n_pass++;
        n_chk++; if (at != 35) $display("FAIL mode0_rvalid_edge: got %0d want 35", at); else n_pass++;
        n_chk++; if (cs_bad != 0) $display("FAIL mode0_cs_low: got %0d bad cycles want 0", cs_bad); else n_pass++;
        n_chk++; if (bus.rdata !== 16'h3C81) $display("FAIL mode0_rdata: got %h want 3c81", bus.rdata); else n_pass++;
        n_chk++; if (mosi_cap !== 16'hA55A) $display("FAIL mode0_mosi: got %h want a55a", mosi_cap); else n_pass++;
        n_chk++; if (rise_cnt != 16) $display("FAIL mode0_sck_rises: got %0d want 16", rise_cnt); else n_pass++;
        n_chk++; if (cs !== 2'b11 || bus.busy !== 1'b0)
            $display("FAIL mode0_end: got cs=%b busy=%b want 11 0", cs, bus.busy); else n_pass++;
        repeat (2) @(posedge clock);
    endtask

    task automatic test_mode3();
        int at;
        int first_chg;
        echo = 16'hFFFE; dev_idx = 0; m_cpol = 1'b1; m_cpha = 1'b1;
        @(negedge clock);
        bus.cpol = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_chk++; if (sck !== 1'b1) $display("FAIL mode3_idle_sck: got %b want 1", sck); else n_pass++;
        kick(16'h8001, 0, 3, 1'b1, 1'b1);
        // Runtime inputs change after acceptance and must not disturb the transfer.
        bus.div = 4'd0; bus.cpol = 1'b0; bus.cpha = 1'b0;
        at = -1; first_chg = -1;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clock);
            #1;
            if (first_chg < 0 && sck !== 1'b1) first_chg = k;
            if (bus.rvalid) begin
                at = k;
                break;
            end
        end
        n_chk++; if (first_chg != 9) $display("FAIL mode3_first_edge: got %0d want 9", first_chg); else n_pass++;
        n_chk++; if (at != 137) $display("FAIL mode3_rvalid_edge: got %0d want 137", at); else n_pass++;
        n_chk++; if (bus.rdata !== 16'hFFFE) $display("FAIL mode3_rdata: got %h want fffe", bus.rdata); else n_pass++;
        n_chk++; if (mosi_cap !== 16'h8001) $display("FAIL mode3_mosi: got %h want 8001", mosi_cap); else n_pass++;
        n_chk++; if (rise_cnt != 16) $display("FAIL mode3_sck_rises: got %0d want 16", rise_cnt); else n_pass++;
        m_cpol = 1'b0; m_cpha = 1'b0;
        repeat (3) @(posedge clock);
    endtask

    task automatic test_overrun();
        int at, ovr_cnt, rv_cnt;
        logic ovr6;
        logic [WIDTH-1:0] rd, mc;
        echo = 16'h0F0F; dev_idx = 0; m_cpol = 1'b0; m_cpha = 1'b0;
        kick(16'h1234, 0, 0, 1'b0, 1'b0);
        at = -1; ovr_cnt = 0; rv_cnt = 0; ovr6 = 1'b0; rd = '0; mc = '0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clock);
            #1;
            if (k == 5) begin bus.wdata = 16'hFFFF; bus.wvalid = 1'b1; end
            if (k == 6) begin bus.wvalid = 1'b0; ovr6 = bus.ovr; end
            if (bus.ovr) ovr_cnt++;
            if (bus.rvalid) begin
                rv_cnt++;
                if (at < 0) begin at = k; rd = bus.rdata; mc = mosi_cap; end
            end
        end
        n_chk++; if (ovr6 !== 1'b1) $display("FAIL ovr_edge6: got %b want 1", ovr6); else n_pass++;
        n_chk++; if (ovr_cnt != 1) $display("FAIL ovr_pulses: got %0d want 1", ovr_cnt); else n_pass++;
        n_chk++; if (at != 35) $display("FAIL ovr_rvalid_edge: got %0d want 35", at); else n_pass++;
        n_chk++; if (rv_cnt != 1) $display("FAIL ovr_rvalid_count: got %0d want 1", rv_cnt); else n_pass++;
        n_chk++; if (mc !== 16'h1234) $display("FAIL ovr_mosi: got %h want 1234", mc); else n_pass++;
        n_chk++; if (rd !== 16'h0F0F) $display("FAIL ovr_rdata: got %h want 0f0f", rd); else n_pass++;
        n_chk++; if (bus.busy !== 1'b0) $display("FAIL ovr_idle_after: got busy=%b want 0", bus.busy); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int at;
        logic [1:0] cs_e1, cs_e2;
        logic busy_e2, ovr_e1;
        echo = 16'h5AA5; dev_idx = 0; m_cpol = 1'b0; m_cpha = 1'b0;
        kick(16'hC3C3, 0, 0, 1'b0, 1'b0);
        wait_rv(60, at);
        n_chk++; if (at != 35) $display("FAIL b2b_first_edge: got %0d want 35", at); else n_pass++;
        n_chk++; if (bus.rdata !== 16'h5AA5) $display("FAIL b2b_first_rdata: got %h want 5aa5", bus.rdata); else n_pass++;
        bus.wdata = 16'h0FF0; bus.wcs = 1'b0; bus.div = 4'd0; bus.wvalid = 1'b1;
        echo = 16'h1111;
        @(posedge clock);
        #1;
        bus.wvalid = 1'b0;
        cs_e1 = cs; ovr_e1 = bus.ovr;
        @(posedge clock);
        #1;
        cs_e2 = cs; busy_e2 = bus.busy;
        n_chk++; if (cs_e1 !== 2'b11 || cs_e2 !== 2'b10)
            $display("FAIL b2b_cs_gap: got %b then %b want 11 then 10", cs_e1, cs_e2); else n_pass++;
        n_chk++; if (busy_e2 !== 1'b1 || ovr_e1 !== 1'b0)
            $display("FAIL b2b_accept: got busy=%b ovr=%b want 1 0", busy_e2, ovr_e1); else n_pass++;
        wait_rv(60, at);
        n_chk++; if (at != 34) $display("FAIL b2b_second_edge: got %0d want 34", at); else n_pass++;
        n_chk++; if (bus.rdata !== 16'h1111) $display("FAIL b2b_second_rdata: got %h want 1111", bus.rdata); else n_pass++;
        n_chk++; if (mosi_cap !== 16'h0FF0) $display("FAIL b2b_second_mosi: got %h want 0ff0", mosi_cap); else n_pass++;
        repeat (2) @(posedge clock);
    endtask

    task automatic test_reset_mid();
        int at, rv_cnt;
        echo = 16'hFFFF; dev_idx = 1; m_cpol = 1'b0; m_cpha = 1'b0;
        kick(16'h0001, 1, 0, 1'b0, 1'b0);
        repeat (10) @(posedge clock);
        #1;
        n_chk++; if (cs !== 2'b01) $display("FAIL rstmid_cs_before: got %b want 01", cs); else n_pass++;
        reset_n = 1'b0;
        #1;
        n_chk++; if (cs !== 2'b11 || sck !== 1'b0 || bus.busy !== 1'b0)
            $display("FAIL rstmid_async: got cs=%b sck=%b busy=%b want 11 0 0", cs, sck, bus.busy); else n_pass++;
        rv_cnt = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clock);
            #1;
            if (bus.rvalid) rv_cnt++;
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int k = 0; k < 40; k++) begin
            @(posedge clock);
            #1;
            if (bus.rvalid) rv_cnt++;
        end
        n_chk++; if (rv_cnt != 0) $display("FAIL rstmid_no_rvalid: got %0d pulses want 0", rv_cnt); else n_pass++;
        echo = 16'h2468;
        kick(16'h1357, 1, 0, 1'b0, 1'b0);
        wait_rv(60, at);
        n_chk++; if (at != 35) $display("FAIL rstmid_next_edge: got %0d want 35", at); else n_pass++;
        n_chk++; if (bus.rdata !== 16'h2468) $display("FAIL rstmid_next_rdata: got %h want 2468", bus.rdata); else n_pass++;
        n_chk++; if (mosi_cap !== 16'h1357) $display("FAIL rstmid_next_mosi: got %h want 1357", mosi_cap); else n_pass++;
        repeat (2) @(posedge clock);
    endtask

    task automatic test_bad_cs();
        int at, cs_bad, toggles;
        logic busy1, sck_last;
        @(negedge clock);
        bus3.wdata = 16'hBEEF; bus3.wcs = 2'd3; bus3.div = 4'd0;
        bus3.cpol = 1'b0; bus3.cpha = 1'b0; bus3.wvalid = 1'b1;
        @(posedge clock);
        #1;
        bus3.wvalid = 1'b0;
        at = -1; cs_bad = 0; toggles = 0; busy1 = 1'b0; sck_last = sck3;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clock);
            #1;
            if (k == 1) busy1 = bus3.busy;
            if (cs3 !== 3'b111) cs_bad++;
            if (sck3 !== sck_last) toggles++;
            sck_last = sck3;
            if (bus3.rvalid) begin
                at = k;
                break;
            end
        end
        n_chk++; if (busy1 !== 1'b1) $display("FAIL badcs_busy: got %b want 1", busy1); else n_pass++;
        n_chk++; if (cs_bad != 0) $display("FAIL badcs_no_cs: got %0d bad cycles want 0", cs_bad); else n_pass++;
        n_chk++; if (toggles != 32) $display("FAIL badcs_sck_toggles: got %0d want 32", toggles); else n_pass++;
        n_chk++; if (at != 35) $display("FAIL badcs_rvalid_edge: got %0d want 35", at); else n_pass++;
        n_chk++; if (bus3.rdata !== 16'h0000) $display("FAIL badcs_rdata: got %h want 0000", bus3.rdata); else n_pass++;
    endtask

    initial begin
        bus.wvalid = 1'b0; bus.wdata = '0; bus.wcs = '0; bus.div = '0; bus.cpol = 1'b0; bus.cpha = 1'b0;
        bus3.wvalid = 1'b0; bus3.wdata = '0; bus3.wcs = '0; bus3.div = '0; bus3.cpol = 1'b0; bus3.cpha = 1'b0;
        test_reset();
        test_mode0();
        test_mode3();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_bad_cs();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
